// File: rtl/freq_divider_mc.sv
// rtl/freq_divider_mc.sv - multi-channel programmable frequency divider
//
// Purpose: derives N_CH independent square waves and one-cycle tick strobes
// from clk_freq1. Each channel has a shadow divisor (written through the cfg
// port) and an active divisor (used for counting). The shadow value is copied
// into active only at a period boundary, on sync_i, or while the channel is
// disabled, so divisor changes never produce runt pulses.
//
// Ports:
//   clk_freq1  system clock, rising edge
//   rst_key1   synchronous active-high reset
//   ch_en      per-channel run enable
//   sync_i     pulse restarting every enabled channel at count 0
//   cfg_we     divisor write strobe
//   cfg_ch     channel index for the write
//   cfg_div    new divisor (must be >= 2)
//   cfg_err    one-cycle pulse after a rejected write
//   freq_2     divided square outputs, registered
//   tick       one-cycle strobe at the end of each period, registered
module freq_divider_mc #(
  parameter int N_CH    = 4,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 104,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_freq1,
  input  logic              rst_key1,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              sync_i,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [N_CH-1:0]   freq_2,
  output logic [N_CH-1:0]   tick
);

  // One extra bit so that an index equal to N_CH (e.g. N_CH a power of two
  // minus nothing representable) still compares correctly.
  localparam logic [CH_W:0] NCH_V = (CH_W+1)'(N_CH);

  logic [DIV_W-1:0] shadow_q [N_CH];
  logic [DIV_W-1:0] shadow_d [N_CH];
  logic [DIV_W-1:0] active_q [N_CH];
  logic [DIV_W-1:0] active_d [N_CH];
  logic [DIV_W-1:0] count_q  [N_CH];
  logic [DIV_W-1:0] count_d  [N_CH];
  logic [N_CH-1:0]  freq_q, freq_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic             err_q, err_d;

  logic             cfg_ok;
  logic             wrap;
  logic [DIV_W-1:0] nxt;

  assign cfg_ok = ({1'b0, cfg_ch} < NCH_V) && (cfg_div >= DIV_W'(2));

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    count_d  = count_q;
    freq_d   = freq_q;
    tick_d   = tick_q;
    err_d    = cfg_we && !cfg_ok;
    wrap     = 1'b0;
    nxt      = '0;
    for (int i = 0; i < N_CH; i++) begin
      wrap = (count_q[i] == active_q[i] - DIV_W'(1));
      nxt  = wrap ? '0 : count_q[i] + DIV_W'(1);
      // The shadow write is independent of the channel's run state; the
      // active copies below read shadow_q, i.e. the pre-write value.
      if (cfg_we && cfg_ok && (cfg_ch == CH_W'(i)))
        shadow_d[i] = cfg_div;
      if (!ch_en[i]) begin
        count_d[i]  = '0;
        freq_d[i]   = 1'b0;
        tick_d[i]   = 1'b0;
        active_d[i] = shadow_q[i];
      end else if (sync_i) begin
        count_d[i]  = '0;
        freq_d[i]   = ((shadow_q[i] >> 1) != '0);
        tick_d[i]   = 1'b0;
        active_d[i] = shadow_q[i];
      end else begin
        count_d[i]  = nxt;
        freq_d[i]   = (nxt < (active_q[i] >> 1));
        tick_d[i]   = wrap;
        if (wrap)
          active_d[i] = shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk_freq1) begin
    if (rst_key1) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= DIV_W'(DEF_DIV);
        active_q[i] <= DIV_W'(DEF_DIV);
        count_q[i]  <= '0;
      end
      freq_q <= '0;
      tick_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        count_q[i]  <= count_d[i];
      end
      freq_q <= freq_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign cfg_err = err_q;
  assign freq_2  = freq_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_freq_divider_mc.sv
// tb/tb_freq_divider_mc.sv - self-checking bench for freq_divider_mc
module tb_freq_divider_mc;

  localparam int NC = 3;

  logic        clk;
  logic        rst;
  logic [2:0]  en;
  logic        sync;
  logic        we;
  logic [1:0]  ch;
  logic [15:0] dv;
  logic        cfg_err;
  logic [2:0]  freq_2;
  logic [2:0]  tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: phase position within the current period plus the
  // programmed and in-use divisors, all as plain integers.
  int   m_sh [NC];
  int   m_act[NC];
  int   m_p  [NC];
  logic [2:0] m_f, m_t;
  logic m_err;

  typedef struct {
    logic        we;
    logic [1:0]  ch;
    logic [15:0] dv;
    logic        err;
  } cfg_vec_t;

  freq_divider_mc #(.N_CH(NC), .DIV_W(16), .DEF_DIV(104)) dut (
    .clk_freq1 (clk),
    .rst_key1  (rst),
    .ch_en     (en),
    .sync_i    (sync),
    .cfg_we    (we),
    .cfg_ch    (ch),
    .cfg_div   (dv),
    .cfg_err   (cfg_err),
    .freq_2    (freq_2),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    int nsh[NC];
    int nact[NC];
    int np[NC];
    logic [2:0] nf, nt;
    logic nerr;
    bit ok;
    ok = (ch < NC) && (dv >= 2);
    nf = '0; nt = '0; nerr = 1'b0;
    for (int c = 0; c < NC; c++) begin
      if (rst) begin
        nsh[c] = 104; nact[c] = 104; np[c] = 0;
      end else begin
        nsh[c] = m_sh[c]; nact[c] = m_act[c]; np[c] = m_p[c];
        if (!en[c]) begin
          np[c] = 0; nf[c] = 1'b0; nt[c] = 1'b0; nact[c] = m_sh[c];
        end else if (sync) begin
          np[c] = 0; nf[c] = (m_sh[c] / 2) > 0; nt[c] = 1'b0; nact[c] = m_sh[c];
        end else begin
          nt[c] = (m_p[c] == m_act[c] - 1);
          np[c] = (m_p[c] + 1) % m_act[c];
          nf[c] = np[c] < (m_act[c] / 2);
          if (nt[c]) nact[c] = m_sh[c];
        end
        if (we && ok && (ch == c)) nsh[c] = dv;
      end
    end
    if (!rst) nerr = we && !ok;
    @(posedge clk);
    #1;
    cyc++;
    m_sh = nsh; m_act = nact; m_p = np; m_f = nf; m_t = nt; m_err = nerr;
    total++;
    if ({cfg_err, tick, freq_2} !== {m_err, m_t, m_f}) begin
      bad++;
      $display("FAIL model cyc=%0d got err/tick/freq=%b/%b/%b expected=%b/%b/%b",
               cyc, cfg_err, tick, freq_2, m_err, m_t, m_f);
    end
  endtask

  // Steps until tick[c] rises; n is the number of edges taken, -1 on timeout.
  task automatic wait_tick(input int c, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (tick[c] === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic write_cfg(input logic [1:0] c, input logic [15:0] d);
    we = 1'b1; ch = c; dv = d;
    step();
    we = 1'b0;
  endtask

  cfg_vec_t vec[8];

  initial begin
    int n, hi, tk0, tk1, tg2, coinc;
    logic [2:0] prev;

    rst = 1'b1; en = 3'b111; sync = 1'b0; we = 1'b0; ch = '0; dv = '0;
    #1;
    step();
    rst = 1'b0;
    chk("reset_outputs", {cfg_err, tick, freq_2}, 0);

    // Default divisor 104 on every channel.
    wait_tick(0, 200, n);
    chk("default_first_tick", n, 104);
    chk("default_all_ticks", tick, 3'b111);
    hi = 0;
    for (int k = 0; k < 104; k++) begin
      step();
      if (freq_2[0]) hi++;
    end
    chk("default_high_cycles", hi, 52);
    chk("default_second_tick", tick[0], 1);

    // Configuration writes with expected cfg_err.
    vec[0] = '{1'b1, 2'd1, 16'd5,     1'b0};
    vec[1] = '{1'b1, 2'd1, 16'd1,     1'b1};
    vec[2] = '{1'b1, 2'd1, 16'd0,     1'b1};
    vec[3] = '{1'b1, 2'd3, 16'd7,     1'b1};
    vec[4] = '{1'b1, 2'd2, 16'hFFFF,  1'b0};
    vec[5] = '{1'b1, 2'd2, 16'd2,     1'b0};
    vec[6] = '{1'b0, 2'd3, 16'd0,     1'b0};
    vec[7] = '{1'b1, 2'd0, 16'd4,     1'b0};
    for (int v = 0; v < 8; v++) begin
      we = vec[v].we; ch = vec[v].ch; dv = vec[v].dv;
      step();
      we = 1'b0;
      chk($sformatf("cfg_err_vec%0d", v), cfg_err, vec[v].err);
      step();
      chk($sformatf("cfg_err_clear%0d", v), cfg_err, 0);
    end

    // Sync: ch0 D=4, ch1 D=5, ch2 D=2 all restart together.
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_freq", freq_2, 3'b111);
    chk("sync_tick", tick, 3'b000);
    tk0 = 0; tk1 = 0; tg2 = 0; hi = 0; prev = freq_2;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tick[0]) tk0++;
      if (tick[1]) tk1++;
      if (freq_2[1]) hi++;
      if (freq_2[2] != prev[2]) tg2++;
      prev = freq_2;
    end
    chk("d4_ticks", tk0, 5);
    chk("d5_ticks", tk1, 4);
    chk("d5_high", hi, 8);
    chk("d2_toggles", tg2, 20);

    // ch0 D=4 and ch1 D=8 aligned by sync: ch0 rises on every ch1 rise.
    write_cfg(2'd1, 16'd8);
    for (int k = 0; k < 3; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_align", freq_2[1:0], 2'b11);
    coinc = 0; prev = freq_2;
    for (int k = 0; k < 24; k++) begin
      step();
      if (freq_2[1] && !prev[1] && !(freq_2[0] && !prev[0])) coinc++;
      prev = freq_2;
    end
    chk("rise_coincide", coinc, 0);

    // Write on the wrap edge: old period of 4 runs once more, then 6.
    wait_tick(0, 10, n);
    for (int k = 0; k < 3; k++) step();
    write_cfg(2'd0, 16'd6);
    chk("wrap_write_tick", tick[0], 1);
    wait_tick(0, 10, n);
    chk("wrap_write_old", n, 4);
    wait_tick(0, 10, n);
    chk("wrap_write_new", n, 6);
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (freq_2[0]) hi++;
    end
    chk("d6_high", hi, 3);

    // Write mid-period: the current 6-period completes, then 4.
    step(); step();
    write_cfg(2'd0, 16'd4);
    wait_tick(0, 10, n);
    chk("mid_write_rest", n, 3);
    wait_tick(0, 10, n);
    chk("mid_write_new", n, 4);

    // Disable ch2 (D=2) for 10 cycles, then re-enable.
    en = 3'b011;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("disabled_ch2", {tick[2], freq_2[2]}, 0);
    end
    en = 3'b111;
    wait_tick(2, 10, n);
    chk("reenable_tick", n, 2);

    // Reset mid-period after programming D=10: back to the 104 waveform.
    write_cfg(2'd0, 16'd10);
    wait_tick(0, 20, n);
    wait_tick(0, 20, n);
    chk("d10_period", n, 10);
    step(); step(); step();
    write_cfg(2'd1, 16'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset_outputs", {cfg_err, tick, freq_2}, 0);
    wait_tick(0, 200, n);
    chk("midreset_tick", n, 104);
    chk("midreset_all", tick, 3'b111);

    // Randomised traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      rst  = ($urandom_range(0, 799) == 0);
      sync = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) en[$urandom_range(0, 2)] ^= 1'b1;
      we = ($urandom_range(0, 7) == 0);
      ch = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 19))
        0, 1:    dv = 16'($urandom_range(0, 1));
        2:       dv = 16'($urandom_range(16'hFFF0, 16'hFFFF));
        default: dv = 16'($urandom_range(2, 12));
      endcase
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_divider_mc.md
# freq_divider_mc

Multi-channel programmable frequency divider that generalises the fixed single-output divider. It derives `N_CH` independent divided square waves and one-cycle tick strobes from the system clock. Each channel's divisor is reprogrammable at run time, and updates are glitch-free because they take effect only at the channel's period boundary. It sits next to the clock source and feeds baud-rate, sampling and display-refresh logic with enables and slow clocks.

## Interface
- `N_CH`, default 4: number of output channels, 1..16.
- `DIV_W`, default 16: divisor width in bits.
- `DEF_DIV`, default 104: reset divisor for every channel (50 MHz / 480 kHz, rounded). Must be ≥2.
- `clk_freq1` in 1: system clock. All logic is on the rising edge.
- `rst_key1` in 1: reset. Synchronous, active-high.
- `ch_en` in N_CH: per-channel run enable.
- `sync_i` in 1: one-cycle pulse that phase-aligns all enabled channels.
- `cfg_we` in 1: divisor write strobe.
- `cfg_ch` in max(1,$clog2(N_CH)): channel index for the write.
- `cfg_div` in DIV_W: new divisor D.
- `cfg_err` out 1: one-cycle pulse when a write is rejected.
- `freq_2` out N_CH: divided square outputs, registered.
- `tick` out N_CH: one-cycle strobe per period, registered.

## Operation
- Per-channel state:
  - `shadow` (DIV_W)
  - `active` (DIV_W)
  - `count` (DIV_W), range 0..active-1
  - `freq_2`, `tick` registers
- Half-period value: H = active>>1. Odd D gives floor(D/2) high cycles and ceil(D/2) low cycles.
- Enabled channel, each edge:
  - count_next = (count == active-1) ? 0 : count+1
  - freq_2 <= (count_next < H)
  - tick <= (count == active-1)
- Wrap edge (count == active-1 while enabled): active <= shadow. The next period uses the new divisor.
- Disabled channel: count <= 0, freq_2 <= 0, tick <= 0, active <= shadow. Re-enabling starts exactly as after reset.
- Config write (cfg_we=1):
  - Accepted if cfg_ch < N_CH and cfg_div ≥ 2. Then shadow[cfg_ch] <= cfg_div.
  - Otherwise nothing changes and cfg_err = 1 on the next cycle.
- sync_i=1: every enabled channel does count <= 0, freq_2 <= (0 < H') with H' = shadow>>1, tick <= 0, active <= shadow. sync_i has no effect on disabled channels.
- Priority per channel, highest first:
  1. rst_key1
  2. ch_en=0
  3. sync_i
  4. normal count/wrap

## Timing
- Reset values: count=0, shadow=active=DEF_DIV, freq_2=0, tick=0, cfg_err=0.
- First enabled edge after reset: count=1. freq_2 then has period D with H high cycles per period.
- tick first rises at edge D after reset release, then every D edges. It is high exactly 1 cycle.
- Write and wrap on the same edge: active loads the pre-write shadow. The written value applies from the following wrap, i.e. the old period completes once more.
- Write to a disabled channel: active reflects the new value 2 edges later (shadow first, then active).
- Write and sync_i on the same edge: active loads the pre-write shadow.
- Reset asserted mid-period: all state returns to reset values on that edge. Pending shadow values are lost.
- D=2: freq_2 toggles every edge, tick fires every second edge.
- D = 2^DIV_W − 1 is legal. No counter overflow is possible.
- cfg_err latency is 1 cycle from the cfg_we edge. There is no other handshake; writes are fire-and-forget.

## Test plan
- Reset, default D=104, ch_en=all 1 → freq_2[0] high 52 cycles and low 52 cycles, repeating. tick[0] first at edge 104, then every 104 edges. All channels are identical.
- ch0 running with D=4; write D=6 to ch0 mid-period → current 4-cycle period completes, the next 4-cycle period also completes (write on wrap edge) or not (write elsewhere), then the period is 6 with 3 high cycles. No runt pulse.
- Write D=5 to ch1 → 2 cycles high, 3 low, tick every 5. Write D=1 → cfg_err pulses for 1 cycle and ch1 is unchanged. Write cfg_ch=N_CH → cfg_err pulses and no channel changes.
- ch0 D=4 and ch1 D=8 at arbitrary phases; pulse sync_i → both counts are 0 on the next cycle and both freq_2 rise together. Thereafter the ch0 rising edges coincide with every ch1 rising edge.
- Drop ch_en[2] for 10 cycles → freq_2[2]=0 and tick[2]=0 while disabled. Re-enable → tick[2] at the D-th edge after re-enable. Other channels are undisturbed.
- Assert rst_key1 for 1 cycle mid-period after programming D=10 → outputs are 0 on the next cycle. The D=104 waveform restarts from count 0.
